// File: rtl/sonic_sync_ring_writer.sv
// Write-side controller for the 2-bit-in / 128-bit-out sync ring: packs a symbol stream into 256 blocks
// of 64 slots, back-pressures against the reader's consumed-block pointer, pads on flush, publishes commits.
module sonic_sync_ring_writer #(
  parameter logic [1:0] PAD_SYMBOL = 2'b00,
  parameter int         DROP_W     = 16
) (
  input  logic              wr_clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              sym_valid,
  input  logic [1:0]        sym_data,
  output logic              sym_ready,
  input  logic              flush,
  input  logic [8:0]        rd_ptr,
  output logic [13:0]       wr_address,
  output logic [1:0]        data_in,
  output logic              wren,
  output logic [8:0]        wr_ptr,
  output logic [8:0]        wr_ptr_gray,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic [1:0]        dbg_state
);

  // Handshake: a symbol transfers in every cycle where sym_valid and sym_ready are both high;
  // sym_ready depends only on registered state and rd_ptr/enable, never on sym_valid.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  state_t            state_q;
  logic [8:0]        blk_q;
  logic [5:0]        idx_q;
  logic              wren_q;
  logic [1:0]        data_q;
  logic [13:0]       addr_q;
  logic              commit_q;
  logic [8:0]        wr_ptr_q;
  logic [8:0]        gray_q;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_q;

  logic [8:0] blk_inc;
  logic [8:0] fill_diff;
  logic [8:0] next_diff;
  logic [8:0] wr_ptr_d;
  logic       space;
  logic       space_next;
  logic       last_slot;
  logic       accept;
  logic       drop;
  state_t     after_block;

  always_comb begin
    blk_inc    = blk_q + 9'd1;
    fill_diff  = blk_q - rd_ptr;
    next_diff  = blk_inc - rd_ptr;
    // (blk - rd_ptr) mod 512 < 256 is exactly "bit 8 of the 9-bit difference is clear".
    space      = ~fill_diff[8];
    space_next = ~next_diff[8];
    wr_ptr_d   = wr_ptr_q + 9'd1;
    last_slot  = (idx_q == 6'd63);
    sym_ready  = (state_q == S_RUN) && space && (enable || (idx_q != 6'd0));
    accept     = sym_valid && sym_ready;
    drop       = sym_valid && !sym_ready && (state_q != S_IDLE);
    if (!enable) begin
      after_block = S_IDLE;
    end else if (space_next) begin
      after_block = S_RUN;
    end else begin
      after_block = S_FULL;
    end
  end

  always_ff @(posedge wr_clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      blk_q      <= '0;
      idx_q      <= '0;
      wren_q     <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      commit_q   <= 1'b0;
      wr_ptr_q   <= '0;
      gray_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wren_q   <= 1'b0;
      commit_q <= 1'b0;
      // Commit lags the last slot's write strobe by one cycle so the RAM write has landed.
      if (commit_q) begin
        wr_ptr_q <= wr_ptr_d;
        gray_q   <= wr_ptr_d ^ (wr_ptr_d >> 1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != DROP_MAX) drop_q <= drop_q + DROP_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (enable) state_q <= space ? S_RUN : S_FULL;
        end
        S_RUN: begin
          if (accept) begin
            wren_q <= 1'b1;
            data_q <= sym_data;
            addr_q <= {blk_q[7:0], idx_q};
            idx_q  <= idx_q + 6'd1;
          end
          if (accept && last_slot) begin
            blk_q    <= blk_inc;
            commit_q <= 1'b1;
            state_q  <= after_block;
          end else if (flush && (idx_q != 6'd0)) begin
            state_q <= S_FLUSH;
          end else if (!enable && (idx_q == 6'd0)) begin
            state_q <= S_IDLE;
          end
        end
        S_FLUSH: begin
          wren_q <= 1'b1;
          data_q <= PAD_SYMBOL;
          addr_q <= {blk_q[7:0], idx_q};
          idx_q  <= idx_q + 6'd1;
          if (last_slot) begin
            blk_q    <= blk_inc;
            commit_q <= 1'b1;
            state_q  <= after_block;
          end
        end
        S_FULL: begin
          if (space) state_q <= enable ? S_RUN : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_address  = addr_q;
  assign data_in     = data_q;
  assign wren        = wren_q;
  assign wr_ptr      = wr_ptr_q;
  assign wr_ptr_gray = gray_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;
  // Debug view of the controller: 0 idle, 1 run, 2 flush, 3 full.
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sonic_sync_ring_writer.sv
// Bench for sonic_sync_ring_writer: directed phases with random symbols, checked every cycle against a
// model that tracks a linear symbol position, an expected-write queue and scheduled block commits.
module tb_sonic_sync_ring_writer;

  localparam int         DROP_W   = 4;
  localparam int         DROP_MAX = 15;
  localparam logic [1:0] PAD      = 2'b00;
  localparam int         M_IDLE   = 0;
  localparam int         M_RUN    = 1;
  localparam int         M_FLUSH  = 2;
  localparam int         M_FULL   = 3;

  // clock / reset / DUT
  logic              wr_clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              sym_valid;
  logic [1:0]        sym_data;
  logic              sym_ready;
  logic              flush;
  logic [8:0]        rd_ptr;
  logic [13:0]       wr_address;
  logic [1:0]        data_in;
  logic              wren;
  logic [8:0]        wr_ptr;
  logic [8:0]        wr_ptr_gray;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;
  logic [1:0]        dbg_state;

  always #5 wr_clock = ~wr_clock;

  sonic_sync_ring_writer #(.PAD_SYMBOL(PAD), .DROP_W(DROP_W)) dut (
    .wr_clock(wr_clock), .reset(reset), .enable(enable), .sym_valid(sym_valid),
    .sym_data(sym_data), .sym_ready(sym_ready), .flush(flush), .rd_ptr(rd_ptr),
    .wr_address(wr_address), .data_in(data_in), .wren(wren), .wr_ptr(wr_ptr),
    .wr_ptr_gray(wr_ptr_gray), .overflow(overflow), .drop_count(drop_count),
    .dbg_state(dbg_state)
  );

  // scoreboard / reference model
  int          checks = 0;
  int          errors = 0;
  int          m_mode;
  int          m_pos;       // linear symbol position, mod 32768 (9-bit block x 64 slots)
  int          m_cyc = 0;
  int          m_commits;
  int          m_accepts;
  int          e_drop;
  bit          e_ovf;
  int          commit_t[$];
  logic [15:0] exp_q[$];    // {address, symbol} of writes due on the next cycle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit space_of(input int blk, input logic [8:0] rdp);
    return ((blk - int'(rdp) + 1024) % 512) < 256;
  endfunction

  function automatic int gray_of(input int p);
    return p ^ (p >> 1);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_commits = 0; m_accepts = 0;
    e_drop = 0; e_ovf = 1'b0;
    commit_t.delete(); exp_q.delete();
  endtask

  task automatic put(input logic [1:0] s);
    exp_q.push_back({14'(m_pos % 16384), s});
    m_pos = (m_pos + 1) % 32768;
  endtask

  task automatic finish_block(input logic en, input logic [8:0] rdp);
    commit_t.push_back(m_cyc + 2);
    if (!en) m_mode = M_IDLE;
    else m_mode = space_of((m_pos / 64) % 512, rdp) ? M_RUN : M_FULL;
  endtask

  // driver: one clock cycle, inputs applied at the falling edge, outputs checked 1 time unit later
  task automatic step(input logic rst, input logic en, input logic v, input logic [1:0] d,
                      input logic fl, input logic [8:0] rdp);
    int blk, idx;
    bit sp, rdy, acc;
    logic [15:0] w;
    @(negedge wr_clock);
    reset = rst; enable = en; sym_valid = v; sym_data = d; flush = fl; rd_ptr = rdp;
    #1;
    blk = (m_pos / 64) % 512;
    idx = m_pos % 64;
    sp  = space_of(blk, rdp);
    rdy = (m_mode == M_RUN) && sp && (en || idx != 0);
    if (rst) begin
      model_reset();
    end else begin
      while (commit_t.size() > 0 && commit_t[0] <= m_cyc) begin
        void'(commit_t.pop_front());
        m_commits++;
      end
      chk("sym_ready", sym_ready, rdy);
      chk("wren", wren, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        if (wren) chk("write_addr_data", {wr_address, data_in}, w);
      end
      chk("wr_ptr", wr_ptr, m_commits % 512);
      chk("wr_ptr_gray", wr_ptr_gray, gray_of(m_commits % 512));
      chk("overflow", overflow, e_ovf);
      chk("drop_count", drop_count, e_drop);
      acc = v && rdy;
      if (v && !rdy && m_mode != M_IDLE) begin
        e_ovf = 1'b1;
        if (e_drop < DROP_MAX) e_drop++;
      end
      if (acc) m_accepts++;
      case (m_mode)
        M_IDLE: if (en) m_mode = sp ? M_RUN : M_FULL;
        M_RUN: begin
          if (acc) put(d);
          if (acc && idx == 63) finish_block(en, rdp);
          else if (fl && idx != 0) m_mode = M_FLUSH;
          else if (!en && idx == 0) m_mode = M_IDLE;
        end
        M_FLUSH: begin
          put(PAD);
          if (idx == 63) finish_block(en, rdp);
        end
        default: if (sp) m_mode = en ? M_RUN : M_IDLE;
      endcase
    end
    m_cyc++;
    @(posedge wr_clock);
  endtask

  task automatic check_reset_outputs(input string t);
    #2;
    chk({t, "_sym_ready"}, sym_ready, 0);
    chk({t, "_wren"}, wren, 0);
    chk({t, "_wr_address"}, wr_address, 0);
    chk({t, "_data_in"}, data_in, 0);
    chk({t, "_wr_ptr"}, wr_ptr, 0);
    chk({t, "_wr_ptr_gray"}, wr_ptr_gray, 0);
    chk({t, "_overflow"}, overflow, 0);
    chk({t, "_drop_count"}, drop_count, 0);
  endtask

  initial begin
    int g;
    int pause;
    bit saw_wrap;
    logic [8:0] rd;
    logic [8:0] prev_gray;
    logic [8:0] prev_ptr;
    reset = 1'b1; enable = 1'b0; sym_valid = 1'b0; sym_data = 2'b00; flush = 1'b0; rd_ptr = '0;
    model_reset();

    // 1: one block of idx%4 symbols, commit two cycles after the last accept
    step(1, 0, 0, 2'd0, 0, 9'd0);
    check_reset_outputs("t1_reset");
    step(0, 1, 0, 2'd0, 0, 9'd0);
    for (int i = 0; i < 64; i++) step(0, 1, 1, 2'(i % 4), 0, 9'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 2'd0, 0, 9'd0);
    #2;
    chk("t1_wr_ptr", wr_ptr, 1);
    chk("t1_gray", wr_ptr_gray, 9'h001);

    // 2: fill all 256 blocks with the reader parked at 0
    step(1, 0, 0, 2'd0, 0, 9'd0);
    step(0, 1, 0, 2'd0, 0, 9'd0);
    g = 0;
    while (m_accepts < 16384 && g < 20000) begin
      step(0, 1, 1, 2'($urandom_range(0, 3)), 0, 9'd0);
      g++;
    end
    chk("t2_stream_bound", m_accepts, 16384);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 2'd0, 0, 9'd0);
    #2;
    chk("t2_wr_ptr", wr_ptr, 256);
    chk("t2_sym_ready", sym_ready, 0);
    chk("t2_state_full", dbg_state, 2'd3);

    // 4: drops while full, then saturation of the narrow counter
    for (int i = 0; i < 5; i++) step(0, 1, 1, 2'd1, 0, 9'd0);
    #2;
    chk("t4_drop5", drop_count, 5);
    chk("t4_overflow", overflow, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 2'd1, 0, 9'd0);
    #2;
    chk("t4_drop_sat", drop_count, DROP_MAX);
    step(0, 1, 0, 2'd0, 0, 9'd1);
    step(0, 1, 1, 2'd2, 0, 9'd1);
    #2;
    chk("t2_resume_wren", wren, 1);
    chk("t2_resume_addr", wr_address, 14'h0000);
    chk("t2_resume_data", data_in, 2'd2);

    // 3: partial block of 10 then flush
    step(1, 0, 0, 2'd0, 0, 9'd0);
    step(0, 1, 0, 2'd0, 0, 9'd0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 2'($urandom_range(0, 3)), 0, 9'd0);
    step(0, 1, 0, 2'd0, 1, 9'd0);
    for (int i = 0; i < 60; i++) step(0, 1, 0, 2'd0, 0, 9'd0);
    #2;
    chk("t3_wr_ptr", wr_ptr, 1);
    step(0, 1, 1, 2'd1, 0, 9'd0);
    #2;
    chk("t3_next_wren", wren, 1);
    chk("t3_next_addr", wr_address, 14'h0040);

    // 5: random traffic with the reader trailing the commits, across the 9-bit wrap
    step(1, 0, 0, 2'd0, 0, 9'd0);
    rd = '0; pause = 0; saw_wrap = 1'b0; prev_gray = '0; prev_ptr = '0; g = 0;
    while (m_commits < 600 && g < 70000) begin
      if ($urandom_range(0, 7) == 0) rd = 9'(m_commits % 512);
      if (pause > 0) pause--;
      else if ($urandom_range(0, 999) == 0) pause = $urandom_range(10, 60);
      step(0, pause == 0, $urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 299) == 0, rd);
      #2;
      if (wr_ptr_gray !== prev_gray) chk("t5_gray_one_bit", $countones(wr_ptr_gray ^ prev_gray), 1);
      if (prev_ptr == 9'd511 && wr_ptr == 9'd0) saw_wrap = 1'b1;
      prev_gray = wr_ptr_gray;
      prev_ptr  = wr_ptr;
      g++;
    end
    chk("t5_block_bound", m_commits >= 600, 1);
    chk("t5_wrap_seen", saw_wrap, 1);

    // 6: reset in the middle of block 3
    step(1, 0, 0, 2'd0, 0, 9'd0);
    step(0, 1, 0, 2'd0, 0, 9'd0);
    g = 0;
    while (m_accepts < 3 * 64 + 20 && g < 1000) begin
      step(0, 1, 1, 2'($urandom_range(0, 3)), 0, 9'd0);
      g++;
    end
    step(1, 1, 1, 2'd2, 0, 9'd0);
    check_reset_outputs("t6_reset");
    step(0, 1, 0, 2'd0, 0, 9'd0);
    step(0, 1, 1, 2'd3, 0, 9'd0);
    #2;
    chk("t6_first_wren", wren, 1);
    chk("t6_first_addr", wr_address, 14'h0000);
    chk("t6_first_data", data_in, 2'd3);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
